// File: rtl/bank_rf_wb_scheduler.sv
// Write-back scheduler for the 2-bank (even/odd) register file: two requests per cycle,
// bank conflicts serialised through a 1-entry holding buffer, post-reset zeroing pass.
module bank_rf_wb_scheduler #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit DROP_R0        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb0_valid_i,
  input  logic [4:0]       wb0_addr_i,
  input  logic [WIDTH-1:0] wb0_data_i,
  output logic             wb0_ready_o,
  input  logic             wb1_valid_i,
  input  logic [4:0]       wb1_addr_i,
  input  logic [WIDTH-1:0] wb1_data_i,
  output logic             wb1_ready_o,
  output logic             rf_we0_o,
  output logic [4:0]       rf_wa0_o,
  output logic [WIDTH-1:0] rf_wd0_o,
  output logic             rf_we1_o,
  output logic [4:0]       rf_wa1_o,
  output logic [WIDTH-1:0] rf_wd1_o,
  output logic             pend_valid_o,
  output logic [4:0]       pend_addr_o,
  output logic [WIDTH-1:0] pend_data_o,
  output logic             init_done_o
);

  typedef enum logic {S_INIT, S_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_INIT : S_RUN;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [4:0]       pa_q, pa_d;
  logic [WIDTH-1:0] pd_q, pd_d;
  logic             we0_q, we0_d, we1_q, we1_d;
  logic [4:0]       wa0_q, wa0_d, wa1_q, wa1_d;
  logic [WIDTH-1:0] wd0_q, wd0_d, wd1_q, wd1_d;
  logic             init_done_q, init_done_d;
  logic             rdy0, rdy1;
  logic             drop0, drop1, live0, live1;

  // Up to two writes issue per cycle; slot order is program order, banks always differ.
  logic [1:0]            iss_v;
  logic [1:0][4:0]       iss_a;
  logic [1:0][WIDTH-1:0] iss_d;

  // Dropped r0 writes count as invalid for every bank check.
  assign drop0 = DROP_R0 && (wb0_addr_i == 5'd0);
  assign drop1 = DROP_R0 && (wb1_addr_i == 5'd0);
  assign live0 = wb0_valid_i && !drop0;
  assign live1 = wb1_valid_i && !drop1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pa_d        = pa_q;
    pd_d        = pd_q;
    we0_d       = 1'b0;
    we1_d       = 1'b0;
    wa0_d       = wa0_q;
    wa1_d       = wa1_q;
    wd0_d       = wd0_q;
    wd1_d       = wd1_q;
    init_done_d = (state_q == S_RUN);
    rdy0        = 1'b0;
    rdy1        = 1'b0;
    iss_v       = '0;
    iss_a       = '0;
    iss_d       = '0;

    case (state_q)
      S_INIT: begin
        we0_d = 1'b1;
        we1_d = 1'b1;
        wa0_d = {cnt_q, 1'b0};
        wa1_d = {cnt_q, 1'b1};
        wd0_d = '0;
        wd1_d = '0;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_RUN;
      end
      S_RUN: begin
        if (!pend_q) begin
          rdy0 = 1'b1;
          rdy1 = 1'b1;
          iss_v[0] = live0;
          iss_a[0] = wb0_addr_i;
          iss_d[0] = wb0_data_i;
          if (live0 && live1 && (wb0_addr_i[0] == wb1_addr_i[0])) begin
            pend_d = 1'b1;
            pa_d   = wb1_addr_i;
            pd_d   = wb1_data_i;
          end else begin
            iss_v[1] = live1;
            iss_a[1] = wb1_addr_i;
            iss_d[1] = wb1_data_i;
          end
        end else begin
          // Buffered entry drains now; wb0 may ride along on the opposite bank.
          rdy0     = drop0 || (wb0_addr_i[0] != pa_q[0]);
          pend_d   = 1'b0;
          iss_v[0] = 1'b1;
          iss_a[0] = pa_q;
          iss_d[0] = pd_q;
          iss_v[1] = live0 && rdy0;
          iss_a[1] = wb0_addr_i;
          iss_d[1] = wb0_data_i;
        end
      end
      default: state_d = RST_STATE;
    endcase

    for (int i = 0; i < 2; i++) begin
      if (iss_v[i]) begin
        if (iss_a[i][0]) begin
          we1_d = 1'b1;
          wa1_d = iss_a[i];
          wd1_d = iss_d[i];
        end else begin
          we0_d = 1'b1;
          wa0_d = iss_a[i];
          wd0_d = iss_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= 4'd0;
      pend_q      <= 1'b0;
      pa_q        <= 5'd0;
      pd_q        <= '0;
      we0_q       <= 1'b0;
      we1_q       <= 1'b0;
      wa0_q       <= 5'd0;
      wa1_q       <= 5'd0;
      wd0_q       <= '0;
      wd1_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pa_q        <= pa_d;
      pd_q        <= pd_d;
      we0_q       <= we0_d;
      we1_q       <= we1_d;
      wa0_q       <= wa0_d;
      wa1_q       <= wa1_d;
      wd0_q       <= wd0_d;
      wd1_q       <= wd1_d;
      init_done_q <= init_done_d;
    end
  end

  // Readys are forced low while reset is held, even when there is no clear pass.
  assign wb0_ready_o  = rdy0 && !rst;
  assign wb1_ready_o  = rdy1 && !rst;
  assign rf_we0_o     = we0_q;
  assign rf_wa0_o     = wa0_q;
  assign rf_wd0_o     = wd0_q;
  assign rf_we1_o     = we1_q;
  assign rf_wa1_o     = wa1_q;
  assign rf_wd1_o     = wd1_q;
  assign pend_valid_o = pend_q;
  assign pend_addr_o  = pa_q;
  assign pend_data_o  = pd_q;
  assign init_done_o  = init_done_q;

endmodule

// File: doc/bank_rf_wb_scheduler.md
Name: bank_rf_wb_scheduler

Overview:
- Write-back scheduler in front of the 2-bank (even/odd address) 6r2w register file.
- Accepts two write-back requests per cycle and guarantees the file never receives two writes to the same bank in one cycle.
- Serialises bank conflicts through a 1-entry holding buffer.
- Runs a post-reset clear sequence that zeroes all 32 registers.

Parameters:
- WIDTH, 32, data width of a register.
- CLEAR_ON_RESET, 1, 1 = run the 16-cycle zeroing sequence after reset; 0 = go straight to RUN.
- DROP_R0, 1, 1 = requests addressed to register 0 are accepted and discarded.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wb0_valid_i  in  1  request 0 valid (older in program order).
- wb0_addr_i  in  5  request 0 register address.
- wb0_data_i  in  WIDTH  request 0 data.
- wb0_ready_o  out  1  request 0 accepted this cycle when high with valid.
- wb1_valid_i  in  1  request 1 valid (younger).
- wb1_addr_i  in  5  request 1 register address.
- wb1_data_i  in  WIDTH  request 1 data.
- wb1_ready_o  out  1  request 1 accepted.
- rf_we0_o / rf_wa0_o / rf_wd0_o  out  1/5/WIDTH  file write port 0; registered; always even bank.
- rf_we1_o / rf_wa1_o / rf_wd1_o  out  1/5/WIDTH  file write port 1; registered; always odd bank.
- pend_valid_o / pend_addr_o / pend_data_o  out  1/5/WIDTH  holding-buffer contents, for the forwarding network.
- init_done_o  out  1  high once the clear sequence is finished.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all rf_we low; rf_wa and rf_wd 0; pend_valid 0; both ready outputs 0; init_done 0; FSM = INIT when CLEAR_ON_RESET is 1, otherwise RUN.
- INIT state:
  - A 4-bit counter c runs 0..15.
  - Each cycle the registered outputs are we0 = we1 = 1, wa0 = {c,0}, wa1 = {c,1}, wd = 0.
  - Both ready outputs stay 0.
  - After the cycle with c = 15, go to RUN. init_done rises on the first RUN cycle.
  - Total: 16 cycles of writes.
- RUN state:
  - Port mapping: even addresses go to port 0, odd addresses go to port 1. An address issued on a port is always a bank-matched address.
  - Latency: a request accepted at edge N appears on rf_* in cycle N+1 (one registered stage). Every accepted write appears exactly once.
- RUN, buffer empty:
  - wb0_ready = wb1_ready = 1.
  - Only one valid, or both valid with different banks: both are issued next cycle on their own bank's port.
  - Both valid, same bank (addr[0] equal, including the same address): wb0 issues next cycle. wb1 is captured into the buffer (pend_valid = 1).
  - Same-address case: wb1 (younger) is therefore written after wb0 and the final value is wb1_data.
- RUN, buffer full:
  - The buffered entry issues next cycle on its bank port and pend_valid clears at that edge.
  - wb1_ready = 0.
  - wb0_ready = 1 only if wb0_addr[0] differs from pend_addr[0]. In that case wb0 co-issues on the other port in the same cycle.
  - Otherwise wb0_ready = 0 and wb0 waits.
  - Maximum stall: 1 cycle per conflict.
- DROP_R0:
  - An accepted request with addr 0 produces no rf_we.
  - It never occupies the buffer and never causes a conflict stall. Bank checks treat it as invalid.
- Ready/valid rules:
  - ready does not depend on the same port's valid.
  - Data and address are sampled only on a valid && ready edge.
  - A requester holding valid with ready low must keep addr and data stable.
- Invariants: rf_we0 implies rf_wa0[0] = 0. rf_we1 implies rf_wa1[0] = 1.
- Reset mid-operation: asserting rst clears the buffer immediately (a pending write is lost by design), drops all we, and restarts INIT from c = 0.
- Invalid cycles: outputs keep the last addr/data with we = 0.

Test Plan:
- Reset release with CLEAR_ON_RESET = 1 -> 16 cycles of we0 = we1 = 1, (wa0, wa1) = (0,1), (2,3) … (30,31), wd = 0; init_done high on cycle 17; readys 0 throughout INIT.
- RUN, wb0 = (addr 4, 0xAAAA), wb1 = (addr 7, 0xBBBB) same cycle -> next cycle we0 = 1, wa0 = 4, we1 = 1, wa1 = 7; no stall; pend_valid stays 0.
- wb0 = (6, 0x11), wb1 = (10, 0x22) -> cycle+1: wa0 = 6, pend_valid = 1, pend_addr = 10, wb1_ready = 0; cycle+2: wa0 = 10, wd0 = 0x22, pend_valid = 0.
- Same address: wb0 = (9, 0x1), wb1 = (9, 0x2) -> wa1 = 9 / wd1 = 0x1, then wa1 = 9 / wd1 = 0x2; a read of r9 afterwards returns 0x2.
- Buffer holds addr 10 while new wb0 = 3 arrives -> wb0_ready = 1; next cycle wa0 = 10 and wa1 = 3 issue together. Repeat with wb0 = 12 -> wb0_ready = 0 for one cycle, then accepted.
- wb0 = (0, 0xFF) with DROP_R0 = 1 -> no we. Then rst pulsed while pend_valid = 1 -> pend_valid = 0 and all we = 0 asynchronously; INIT restarts at wa0 = 0.
